// File: rtl/rob_commit_unit.sv
// Reorder buffer for the Tomasulo core: allocates rename tags, captures CDB results,
// answers operand-readiness queries and retires entries in program order to the regfile.
module rob_commit_unit #(
  parameter int ROB_SIZE = 16,
  parameter int TAG_W    = 4,
  parameter int REG_W    = 5,
  parameter int DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ena,
  input  logic              in_issue_valid,
  input  logic [REG_W-1:0]  in_issue_rd,
  output logic [TAG_W-1:0]  out_issue_tag,
  output logic              out_full,
  input  logic              in_cdb_valid,
  input  logic [TAG_W-1:0]  in_cdb_tag,
  input  logic [DATA_W-1:0] in_cdb_value,
  input  logic [TAG_W-1:0]  in_query_tag1,
  input  logic [TAG_W-1:0]  in_query_tag2,
  output logic              out_query_ready1,
  output logic              out_query_ready2,
  output logic [DATA_W-1:0] out_query_value1,
  output logic [DATA_W-1:0] out_query_value2,
  input  logic              in_flush,
  output logic              out_commit_valid,
  output logic [REG_W-1:0]  out_commit_reg_index,
  output logic [TAG_W-1:0]  out_commit_tag,
  output logic [DATA_W-1:0] out_commit_value
);

  localparam logic [TAG_W-1:0] FIRST_TAG = TAG_W'(1);
  localparam logic [TAG_W-1:0] LAST_TAG  = TAG_W'(ROB_SIZE - 1);

  logic [ROB_SIZE-1:0] busy_q;
  logic [ROB_SIZE-1:0] ready_q;
  logic [REG_W-1:0]    rd_q    [ROB_SIZE];
  logic [DATA_W-1:0]   value_q [ROB_SIZE];
  logic [TAG_W-1:0]    head_q;
  logic [TAG_W-1:0]    tail_q;
  logic [TAG_W-1:0]    count_q;

  logic issue_fire;
  logic cdb_accept;
  logic commit_fire;

  // Tag 0 means "no tag", so the pointer sequence skips it on wrap.
  function automatic logic [TAG_W-1:0] next_tag(input logic [TAG_W-1:0] t);
    return (t == LAST_TAG) ? FIRST_TAG : t + TAG_W'(1);
  endfunction

  assign out_issue_tag = tail_q;
  assign out_full      = (count_q == LAST_TAG);

  // Full is judged on the pre-edge count, so a same-cycle retire does not admit an issue.
  assign issue_fire  = in_issue_valid && !out_full;
  assign cdb_accept  = in_cdb_valid && (in_cdb_tag != '0) &&
                       busy_q[in_cdb_tag] && !ready_q[in_cdb_tag];
  assign commit_fire = busy_q[head_q] && ready_q[head_q];

  logic [TAG_W-1:0]  q_tag   [2];
  logic              q_ready [2];
  logic [DATA_W-1:0] q_value [2];

  assign q_tag[0] = in_query_tag1;
  assign q_tag[1] = in_query_tag2;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    for (int p = 0; p < 2; p++) begin
      q_ready[p] = 1'b0;
      q_value[p] = '0;
      if (q_tag[p] == '0) begin
        q_ready[p] = 1'b1;
      end else if (ready_q[q_tag[p]]) begin
        q_ready[p] = 1'b1;
        q_value[p] = value_q[q_tag[p]];
      end else if (in_cdb_valid && (in_cdb_tag == q_tag[p])) begin
        q_ready[p] = 1'b1;
        q_value[p] = in_cdb_value;
      end
    end
  end

  assign out_query_ready1 = q_ready[0];
  assign out_query_ready2 = q_ready[1];
  assign out_query_value1 = q_value[0];
  assign out_query_value2 = q_value[1];

  // NOTE: all sequential state uses non-blocking assignments so every read sees pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q               <= FIRST_TAG;
      tail_q               <= FIRST_TAG;
      count_q              <= '0;
      busy_q               <= '0;
      ready_q              <= '0;
      out_commit_valid     <= 1'b0;
      out_commit_reg_index <= '0;
      out_commit_tag       <= '0;
      out_commit_value     <= '0;
    end else if (ena) begin
      if (in_flush) begin
        head_q               <= FIRST_TAG;
        tail_q               <= FIRST_TAG;
        count_q              <= '0;
        busy_q               <= '0;
        ready_q              <= '0;
        out_commit_valid     <= 1'b0;
        out_commit_reg_index <= '0;
        out_commit_tag       <= '0;
        out_commit_value     <= '0;
      end else begin
        out_commit_valid     <= 1'b0;
        out_commit_reg_index <= '0;
        out_commit_tag       <= '0;
        out_commit_value     <= '0;

        // Issue, CDB and commit always touch distinct entries: tail is never busy
        // when issue fires, and a ready head ignores the CDB.
        if (issue_fire) begin
          busy_q[tail_q]  <= 1'b1;
          ready_q[tail_q] <= 1'b0;
          tail_q          <= next_tag(tail_q);
        end

        if (cdb_accept) begin
          ready_q[in_cdb_tag] <= 1'b1;
        end

        if (commit_fire) begin
          busy_q[head_q]       <= 1'b0;
          ready_q[head_q]      <= 1'b0;
          head_q               <= next_tag(head_q);
          out_commit_valid     <= 1'b1;
          out_commit_reg_index <= rd_q[head_q];
          out_commit_tag       <= head_q;
          out_commit_value     <= value_q[head_q];
        end

        case ({issue_fire, commit_fire})
          2'b10:   count_q <= count_q + TAG_W'(1);
          2'b01:   count_q <= count_q - TAG_W'(1);
          default: count_q <= count_q;
        endcase
      end
    end
  end

  // NOTE: the payload arrays are not reset; busy/ready gate every use of them.
  always_ff @(posedge clk) begin
    if (ena && !in_flush) begin
      if (issue_fire) begin
        rd_q[tail_q] <= in_issue_rd;
      end
      if (cdb_accept) begin
        value_q[in_cdb_tag] <= in_cdb_value;
      end
    end
  end

endmodule

// File: tb/tb_rob_commit_unit.sv
// Self-checking bench for rob_commit_unit: directed vector table, hand-written corner
// sequences, and a randomized run against a queue-based program-order model.
module tb_rob_commit_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        ena;
  logic        in_issue_valid;
  logic [4:0]  in_issue_rd;
  logic [3:0]  out_issue_tag;
  logic        out_full;
  logic        in_cdb_valid;
  logic [3:0]  in_cdb_tag;
  logic [31:0] in_cdb_value;
  logic [3:0]  in_query_tag1;
  logic [3:0]  in_query_tag2;
  logic        out_query_ready1;
  logic        out_query_ready2;
  logic [31:0] out_query_value1;
  logic [31:0] out_query_value2;
  logic        in_flush;
  logic        out_commit_valid;
  logic [4:0]  out_commit_reg_index;
  logic [3:0]  out_commit_tag;
  logic [31:0] out_commit_value;

  int tests = 0;
  int fails = 0;

  rob_commit_unit dut (
    .clk(clk), .rst(rst), .ena(ena),
    .in_issue_valid(in_issue_valid), .in_issue_rd(in_issue_rd),
    .out_issue_tag(out_issue_tag), .out_full(out_full),
    .in_cdb_valid(in_cdb_valid), .in_cdb_tag(in_cdb_tag), .in_cdb_value(in_cdb_value),
    .in_query_tag1(in_query_tag1), .in_query_tag2(in_query_tag2),
    .out_query_ready1(out_query_ready1), .out_query_ready2(out_query_ready2),
    .out_query_value1(out_query_value1), .out_query_value2(out_query_value2),
    .in_flush(in_flush),
    .out_commit_valid(out_commit_valid), .out_commit_reg_index(out_commit_reg_index),
    .out_commit_tag(out_commit_tag), .out_commit_value(out_commit_value)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic set_in(input logic iv, input logic [4:0] rd, input logic cv,
                        input logic [3:0] ct, input logic [31:0] cval, input logic fl);
    ena = 1'b1; in_issue_valid = iv; in_issue_rd = rd;
    in_cdb_valid = cv; in_cdb_tag = ct; in_cdb_value = cval; in_flush = fl;
    in_query_tag1 = 4'd0; in_query_tag2 = 4'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_commit(input string name, input logic cv, input logic [4:0] reg_i,
                              input logic [3:0] tag, input logic [31:0] val);
    check({name, ".valid"}, 64'(out_commit_valid), 64'(cv));
    check({name, ".reg"},   64'(out_commit_reg_index), 64'(reg_i));
    check({name, ".tag"},   64'(out_commit_tag), 64'(tag));
    check({name, ".value"}, 64'(out_commit_value), 64'(val));
  endtask

  task automatic do_reset();
    set_in(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    check_commit("reset", 1'b0, 5'd0, 4'd0, 32'd0);
    check("reset.issue_tag", 64'(out_issue_tag), 64'd1);
    check("reset.full", 64'(out_full), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();
  endtask

  // ---------------- behavioural model: program-order queue of live instructions
  typedef struct {
    logic [3:0]  tag;
    logic [4:0]  rd;
    bit          done;
    logic [31:0] val;
  } ent_t;

  ent_t        m_q[$];
  int          m_alloc;
  logic        m_cv;
  logic [4:0]  m_creg;
  logic [3:0]  m_ctag;
  logic [31:0] m_cval;

  function automatic void model_reset();
    m_q.delete();
    m_alloc = 1;
    m_cv = 1'b0; m_creg = '0; m_ctag = '0; m_cval = '0;
  endfunction

  function automatic void model_query(input logic [3:0] tag, output logic r, output logic [31:0] v);
    r = 1'b0; v = '0;
    if (tag == 4'd0) begin
      r = 1'b1;
      return;
    end
    foreach (m_q[i]) begin
      if (m_q[i].tag == tag && m_q[i].done) begin
        r = 1'b1; v = m_q[i].val;
        return;
      end
    end
    if (in_cdb_valid && in_cdb_tag == tag) begin
      r = 1'b1; v = in_cdb_value;
    end
  endfunction

  function automatic void model_step();
    bit was_full, can_commit;
    ent_t e;
    if (!ena) return;
    if (in_flush) begin
      model_reset();
      return;
    end
    was_full   = (m_q.size() == 15);
    can_commit = (m_q.size() > 0) && m_q[0].done;
    if (in_cdb_valid && in_cdb_tag != 4'd0) begin
      foreach (m_q[i]) begin
        if (m_q[i].tag == in_cdb_tag && !m_q[i].done) begin
          m_q[i].done = 1'b1;
          m_q[i].val  = in_cdb_value;
        end
      end
    end
    if (can_commit) begin
      e = m_q.pop_front();
      m_cv = 1'b1; m_creg = e.rd; m_ctag = e.tag; m_cval = e.val;
    end else begin
      m_cv = 1'b0; m_creg = '0; m_ctag = '0; m_cval = '0;
    end
    if (in_issue_valid && !was_full) begin
      e.tag = 4'(m_alloc); e.rd = in_issue_rd; e.done = 1'b0; e.val = '0;
      m_q.push_back(e);
      m_alloc = (m_alloc == 15) ? 1 : m_alloc + 1;
    end
  endfunction

  // ---------------- directed vector table
  typedef struct {
    logic iv; logic [4:0] rd; logic cv; logic [3:0] ct; logic [31:0] cval; logic en;
    logic [3:0] qt1; logic [3:0] qt2;
    logic e_full; logic [3:0] e_itag;
    logic e_qr1; logic [31:0] e_qv1; logic e_qr2; logic [31:0] e_qv2;
    logic e_cv; logic [4:0] e_creg; logic [3:0] e_ctag; logic [31:0] e_cval;
  } vec_t;

  vec_t vecs[17];

  initial begin
    logic r1, r2;
    logic [31:0] v1, v2;

    rst = 1'b0;
    set_in(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    #12;
    do_reset();

    //          iv rd    cv ct    cval          en qt1 qt2  full itag qr1 qv1            qr2 qv2        cv creg ctag cval
    vecs[0]  = '{1, 5'd5, 0, 4'd0, 32'h0,        1, 0,  1,   0,  1,   1, 32'h0,         0, 32'h0,      0, 0,   0,   32'h0};
    vecs[1]  = '{0, 5'd0, 1, 4'd1, 32'hDEADBEEF, 1, 1,  2,   0,  2,   1, 32'hDEADBEEF,  0, 32'h0,      0, 0,   0,   32'h0};
    vecs[2]  = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 1,  0,   0,  2,   1, 32'hDEADBEEF,  1, 32'h0,      1, 5,   1,   32'hDEADBEEF};
    vecs[3]  = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 1,  0,   0,  2,   0, 32'h0,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[4]  = '{1, 5'd7, 0, 4'd0, 32'h0,        1, 0,  0,   0,  2,   1, 32'h0,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[5]  = '{1, 5'd8, 0, 4'd0, 32'h0,        1, 0,  0,   0,  3,   1, 32'h0,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[6]  = '{1, 5'd9, 0, 4'd0, 32'h0,        1, 0,  0,   0,  4,   1, 32'h0,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[7]  = '{0, 5'd0, 1, 4'd4, 32'h7,        1, 4,  0,   0,  5,   1, 32'h7,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[8]  = '{0, 5'd0, 1, 4'd3, 32'h33,       1, 4,  3,   0,  5,   1, 32'h7,         1, 32'h33,     0, 0,   0,   32'h0};
    vecs[9]  = '{0, 5'd0, 1, 4'd2, 32'h22,       1, 2,  3,   0,  5,   1, 32'h22,        1, 32'h33,     0, 0,   0,   32'h0};
    vecs[10] = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 2,  0,   0,  5,   1, 32'h22,        1, 32'h0,      1, 7,   2,   32'h22};
    vecs[11] = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 2,  3,   0,  5,   0, 32'h0,         1, 32'h33,     1, 8,   3,   32'h33};
    vecs[12] = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 4,  0,   0,  5,   1, 32'h7,         1, 32'h0,      1, 9,   4,   32'h7};
    vecs[13] = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 4,  0,   0,  5,   0, 32'h0,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[14] = '{0, 5'd0, 1, 4'd0, 32'h55,       1, 0,  6,   0,  5,   1, 32'h0,         0, 32'h0,      0, 0,   0,   32'h0};
    vecs[15] = '{1, 5'd3, 0, 4'd0, 32'h0,        0, 0,  0,   0,  5,   1, 32'h0,         1, 32'h0,      0, 0,   0,   32'h0};
    vecs[16] = '{0, 5'd0, 0, 4'd0, 32'h0,        1, 0,  5,   0,  5,   1, 32'h0,         0, 32'h0,      0, 0,   0,   32'h0};

    for (int i = 0; i < 17; i++) begin
      set_in(vecs[i].iv, vecs[i].rd, vecs[i].cv, vecs[i].ct, vecs[i].cval, 1'b0);
      ena = vecs[i].en;
      in_query_tag1 = vecs[i].qt1;
      in_query_tag2 = vecs[i].qt2;
      #1;
      check($sformatf("vec%0d.full", i), 64'(out_full), 64'(vecs[i].e_full));
      check($sformatf("vec%0d.issue_tag", i), 64'(out_issue_tag), 64'(vecs[i].e_itag));
      check($sformatf("vec%0d.qready1", i), 64'(out_query_ready1), 64'(vecs[i].e_qr1));
      check($sformatf("vec%0d.qvalue1", i), 64'(out_query_value1), 64'(vecs[i].e_qv1));
      check($sformatf("vec%0d.qready2", i), 64'(out_query_ready2), 64'(vecs[i].e_qr2));
      check($sformatf("vec%0d.qvalue2", i), 64'(out_query_value2), 64'(vecs[i].e_qv2));
      tick();
      check_commit($sformatf("vec%0d.commit", i), vecs[i].e_cv, vecs[i].e_creg,
                   vecs[i].e_ctag, vecs[i].e_cval);
    end

    // In-order retirement of out-of-order completions.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 5'(i), 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    for (int i = 3; i >= 1; i--) begin
      set_in(1'b0, 5'd0, 1'b1, 4'(i), 32'(32'h100 + i), 1'b0);
      tick();
      check_commit($sformatf("ooo.cdb%0d", i), 1'b0, 5'd0, 4'd0, 32'd0);
    end
    set_in(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_commit($sformatf("ooo.retire%0d", i), 1'b1, 5'(i), 4'(i), 32'(32'h100 + i));
    end
    tick();
    check_commit("ooo.after", 1'b0, 5'd0, 4'd0, 32'd0);

    // Fill to capacity, blocked issue during a freeing commit, then wrap to tag 1.
    do_reset();
    for (int i = 1; i <= 15; i++) begin
      set_in(1'b1, 5'(i), 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    check("full.full", 64'(out_full), 64'd1);
    check("full.issue_tag", 64'(out_issue_tag), 64'd1);
    set_in(1'b1, 5'd31, 1'b1, 4'd1, 32'hA1, 1'b0);
    tick();
    check("full.blocked", 64'(out_full), 64'd1);
    set_in(1'b1, 5'd30, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    check_commit("full.commit", 1'b1, 5'd1, 4'd1, 32'hA1);
    check("full.freed", 64'(out_full), 64'd0);
    check("full.next_tag", 64'(out_issue_tag), 64'd1);
    set_in(1'b1, 5'd29, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    check("full.refill", 64'(out_full), 64'd1);
    check("full.tag_after", 64'(out_issue_tag), 64'd2);

    // Flush on the same edge the head becomes committable.
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      set_in(1'b1, 5'(i + 10), 1'b0, 4'd0, 32'd0, 1'b0);
      tick();
    end
    set_in(1'b0, 5'd0, 1'b1, 4'd1, 32'hF00D, 1'b0);
    tick();
    set_in(1'b1, 5'd20, 1'b1, 4'd2, 32'hBEEF, 1'b1);
    tick();
    check_commit("flush.commit", 1'b0, 5'd0, 4'd0, 32'd0);
    check("flush.issue_tag", 64'(out_issue_tag), 64'd1);
    check("flush.full", 64'(out_full), 64'd0);
    set_in(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    in_query_tag1 = 4'd1;
    #1;
    check("flush.qready", 64'(out_query_ready1), 64'd0);
    tick();
    check_commit("flush.after", 1'b0, 5'd0, 4'd0, 32'd0);

    // ena hold with a ready head, then async reset during a commit cycle.
    do_reset();
    set_in(1'b1, 5'd4, 1'b0, 4'd0, 32'd0, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 1'b1, 4'd1, 32'h99, 1'b0);
    tick();
    set_in(1'b0, 5'd0, 1'b0, 4'd0, 32'd0, 1'b0);
    ena = 1'b0;
    in_query_tag1 = 4'd1;
    for (int i = 0; i < 2; i++) begin
      tick();
      check_commit($sformatf("hold%0d", i), 1'b0, 5'd0, 4'd0, 32'd0);
      check($sformatf("hold%0d.issue_tag", i), 64'(out_issue_tag), 64'd2);
      check($sformatf("hold%0d.qvalue", i), 64'(out_query_value1), 64'h99);
    end
    ena = 1'b1;
    tick();
    check_commit("resume", 1'b1, 5'd4, 4'd1, 32'h99);
    #2;
    rst = 1'b0;
    #1;
    check_commit("async_rst", 1'b0, 5'd0, 4'd0, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    tick();

    // Randomized run against the program-order model.
    do_reset();
    model_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      ena            = ($urandom_range(0, 7) != 0);
      in_flush       = ($urandom_range(0, 40) == 0);
      in_issue_valid = ($urandom_range(0, 1) == 1);
      in_issue_rd    = 5'($urandom_range(0, 31));
      in_cdb_valid   = ($urandom_range(0, 2) != 0);
      if (m_q.size() > 0 && $urandom_range(0, 3) != 0)
        in_cdb_tag = m_q[$urandom_range(0, m_q.size() - 1)].tag;
      else
        in_cdb_tag = 4'($urandom_range(0, 15));
      in_cdb_value  = $urandom;
      in_query_tag1 = 4'($urandom_range(0, 15));
      in_query_tag2 = (m_q.size() > 0) ? m_q[0].tag : 4'd0;
      #1;
      model_query(in_query_tag1, r1, v1);
      model_query(in_query_tag2, r2, v2);
      check("rnd.full", 64'(out_full), 64'(m_q.size() == 15));
      check("rnd.issue_tag", 64'(out_issue_tag), 64'(m_alloc));
      check("rnd.qready1", 64'(out_query_ready1), 64'(r1));
      check("rnd.qvalue1", 64'(out_query_value1), 64'(v1));
      check("rnd.qready2", 64'(out_query_ready2), 64'(r2));
      check("rnd.qvalue2", 64'(out_query_value2), 64'(v2));
      @(posedge clk);
      model_step();
      #1;
      check_commit("rnd.commit", m_cv, m_creg, m_ctag, m_cval);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rob_commit_unit.md
Name: rob_commit_unit

Overview:
- Reorder buffer for the Tomasulo core.
- Allocates rename tags to decoded instructions and captures results broadcast on the CDB.
- Answers operand-readiness queries by tag.
- Retires instructions in program order. On retire it drives the register file's commit port (reg index, entry tag, new value), which is the other end of the regfile's "set value by rob" interface.

Parameters:
- ROB_SIZE, 16, number of tag slots. Tag 0 is reserved as "no tag", so ROB_SIZE-1 entries are usable.
- TAG_W, 4, tag width; equals log2(ROB_SIZE).
- REG_W, 5, architectural register index width.
- DATA_W, 32, data width.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- ena  in  1  1 = normal operation; 0 = all state and outputs hold.
- in_issue_valid  in  1  decoder requests an entry.
- in_issue_rd  in  REG_W  destination register; 0 = no writeback.
- out_issue_tag  out  TAG_W  tag the next issue receives (combinational, equals tail).
- out_full  out  1  no free entry (combinational).
- in_cdb_valid  in  1  result broadcast valid.
- in_cdb_tag  in  TAG_W  producing tag.
- in_cdb_value  in  DATA_W  result value.
- in_query_tag1  in  TAG_W  operand-1 tag from the regfile lookup.
- in_query_tag2  in  TAG_W  operand-2 tag.
- out_query_ready1  out  1  operand-1 value available (combinational).
- out_query_ready2  out  1  operand-2 value available (combinational).
- out_query_value1  out  DATA_W  operand-1 value.
- out_query_value2  out  DATA_W  operand-2 value.
- in_flush  in  1  branch-mispredict flush.
- out_commit_valid  out  1  one retire occurred this cycle.
- out_commit_reg_index  out  REG_W  regfile write index; 0 when not committing.
- out_commit_tag  out  TAG_W  retiring tag; 0 when not committing.
- out_commit_value  out  DATA_W  retiring value; 0 when not committing.

Behaviour:
- Storage: per entry, busy, ready, rd, value. Head, tail and count are registered. Tags run 1..ROB_SIZE-1; increment wraps ROB_SIZE-1 -> 1 and never yields 0.
- Reset (rst=0, asynchronous):
  - head=tail=1, count=0, all busy/ready=0.
  - All commit outputs 0.
  - Hence out_issue_tag=1 and out_full=0.
- ena=0: no register changes. Combinational outputs still track the inputs.
- out_full = (count == ROB_SIZE-1).
- Issue: in_issue_valid && !out_full at an edge:
  - entry[tail] gets busy=1, ready=0, rd=in_issue_rd;
  - tail advances;
  - count increments.
  - in_issue_valid while full is ignored, even if a commit frees an entry in the same cycle.
- CDB: in_cdb_valid at an edge with entry[in_cdb_tag] busy and not ready:
  - value is stored and ready set to 1.
  - A CDB to a non-busy entry or to tag 0 is ignored.
- Commit (at most one per edge): if entry[head] busy && ready at the edge:
  - register out_commit_valid=1, out_commit_reg_index=rd, out_commit_tag=head, out_commit_value=value;
  - clear busy/ready of the entry;
  - head advances;
  - count decrements.
  - Otherwise all four commit outputs are registered to 0.
  - The outputs last exactly one cycle per retire.
- Commit latency: a CDB write at edge N makes the head committable at edge N+1. The regfile samples at edge N+2.
- Simultaneous issue and commit: count is unchanged, both pointers advance.
- Simultaneous CDB to the head entry and a commit check in the same edge: the commit uses the pre-edge ready, so the retire happens one edge later.
- Query, per port:
  - tag 0 -> ready=1, value=0.
  - entry ready -> ready=1, value=entry value.
  - else if in_cdb_valid && in_cdb_tag == query tag -> ready=1, value=in_cdb_value (bypass).
  - else ready=0, value=0.
- Flush (ena=1): has priority over issue, CDB and commit at that edge.
  - head=tail=1, count=0, all busy/ready cleared;
  - commit outputs registered to 0.
  - The regfile's busy bits are cleared by the decoder/regfile path, not by this block.
- An asynchronous reset mid-commit clears the commit outputs immediately.

Test Plan:
- Reset, then issue rd=5 (tag 1); CDB tag1 value 0xDEADBEEF at edge N -> out_commit_valid=1, reg=5, tag=1, value=0xDEADBEEF during the cycle after edge N+1; outputs 0 one cycle later.
- Issue tags 1,2,3 (rd 1,2,3); CDB completes 3, then 2, then 1 -> commits emerge strictly in order 1,2,3 on consecutive cycles after tag 1 completes.
- Issue 15 entries -> out_full=1, out_issue_tag=1 (wrapped); a 16th issue is ignored; after one commit, out_full=0 and the next issue receives tag 1.
- Query tag 4 while entry 4 is pending with CDB tag4 value 7 in the same cycle -> ready=1, value=7 combinationally; query tag 0 -> ready=1, value=0.
- Issue 3 entries, CDB completes the head, assert in_flush on the same edge as the commit check -> no commit; head=tail=1, count=0, out_issue_tag=1.
- Deassert ena with the head ready -> no commit and no pointer change; reassert ena -> commit on the next edge. Assert rst=0 mid-cycle -> commit outputs drop to 0 immediately.
